// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu
// Description : Combinational ALU plus a multi-cycle multiply/divide unit
//               with HI/LO result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] iA1,
    input  logic [WIDTH-1:0] iA2,
    input  logic [3:0]       iop,
    input  logic             istart,
    output logic [WIDTH-1:0] out,
    output logic             ooverflow,
    output logic             obusy,
    output logic [WIDTH-1:0] ohi,
    output logic [WIDTH-1:0] olo
);

    localparam int c_MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_OR    = 4'd2;
    localparam logic [3:0] c_OP_AND   = 4'd3;
    localparam logic [3:0] c_OP_XOR   = 4'd4;
    localparam logic [3:0] c_OP_SLT   = 4'd5;
    localparam logic [3:0] c_OP_SLTU  = 4'd6;
    localparam logic [3:0] c_OP_NOR   = 4'd7;
    localparam logic [3:0] c_OP_MULT  = 4'd8;
    localparam logic [3:0] c_OP_MULTU = 4'd9;
    localparam logic [3:0] c_OP_DIV   = 4'd10;
    localparam logic [3:0] c_OP_DIVU  = 4'd11;
    localparam logic [3:0] c_OP_MTHI  = 4'd12;
    localparam logic [3:0] c_OP_MTLO  = 4'd13;

    // ---------------------------------------------------------------- ALU
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic             w_slt;
    logic             w_sltu;

    assign w_sum     = iA1 + iA2;
    assign w_diff    = iA1 - iA2;
    assign w_ovf_add = (iA1[WIDTH-1] == iA2[WIDTH-1]) && (w_sum[WIDTH-1]  != iA1[WIDTH-1]);
    assign w_ovf_sub = (iA1[WIDTH-1] != iA2[WIDTH-1]) && (w_diff[WIDTH-1] != iA1[WIDTH-1]);
    assign w_slt     = $signed(iA1) < $signed(iA2);
    assign w_sltu    = iA1 < iA2;

    always_comb begin
        out       = '0;
        ooverflow = 1'b0;
        case (iop)
            c_OP_SUB: begin
                out       = w_diff;
                ooverflow = w_ovf_sub;
            end
            c_OP_OR:   out = iA1 | iA2;
            c_OP_AND:  out = iA1 & iA2;
            c_OP_XOR:  out = iA1 ^ iA2;
            c_OP_SLT:  out = {{(WIDTH-1){1'b0}}, w_slt};
            c_OP_SLTU: out = {{(WIDTH-1){1'b0}}, w_sltu};
            c_OP_NOR:  out = ~(iA1 | iA2);
            c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU, c_OP_MTHI, c_OP_MTLO: begin
                out       = '0;
                ooverflow = 1'b0;
            end
            default: begin
                out       = w_sum;
                ooverflow = w_ovf_add;
            end
        endcase
    end

    // ---------------------------------------------------------------- MDU
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Sign-extending to 2*WIDTH makes the modular product equal the signed one.
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed divide on magnitudes; MIN / -1 wraps naturally to LO = MIN, HI = 0.
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic [WIDTH-1:0] w_sq;
    logic [WIDTH-1:0] w_sr;

    assign w_neg_a = r_a[WIDTH-1];
    assign w_neg_b = r_b[WIDTH-1];
    assign w_abs_a = w_neg_a ? ('0 - r_a) : r_a;
    assign w_abs_b = w_neg_b ? ('0 - r_b) : r_b;
    assign w_uq    = w_abs_a / w_abs_b;
    assign w_ur    = w_abs_a % w_abs_b;
    assign w_sq    = (w_neg_a ^ w_neg_b) ? ('0 - w_uq) : w_uq;
    assign w_sr    = w_neg_a ? ('0 - w_ur) : w_ur;

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_res_we;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_we = 1'b0;
        case (r_op)
            c_OP_MULT: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_we             = 1'b1;
            end
            c_OP_MULTU: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_we             = 1'b1;
            end
            c_OP_DIV: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
                w_res_we = (r_b != '0);
            end
            c_OP_DIVU: begin
                w_res_hi = r_a % r_b;
                w_res_lo = r_a / r_b;
                w_res_we = (r_b != '0);
            end
            default: w_res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= c_OP_ADD;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
                if (w_res_we) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end else if (istart) begin
            case (iop)
                c_OP_MULT, c_OP_MULTU: begin
                    r_a    <= iA1;
                    r_b    <= iA2;
                    r_op   <= iop;
                    r_busy <= 1'b1;
                    r_cnt  <= c_MUL_LOAD;
                end
                c_OP_DIV, c_OP_DIVU: begin
                    r_a    <= iA1;
                    r_b    <= iA2;
                    r_op   <= iop;
                    r_busy <= 1'b1;
                    r_cnt  <= c_DIV_LOAD;
                end
                c_OP_MTHI: r_hi <= iA1;
                c_OP_MTLO: r_lo <= iA1;
                default: ;
            endcase
        end
    end

    assign obusy = r_busy;
    assign ohi   = r_hi;
    assign olo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mdu
// Description : Self-checking bench for alu_mdu against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a1, a2, out, hi, lo;
    logic [3:0]  op;
    logic        start, ovf, busy;

    logic [15:0] b1, b2, out16, hi16, lo16;
    logic [3:0]  op16;
    logic        start16, ovf16, busy16;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_hilo = 64'd0;

    always #5 clk = ~clk;

    alu_mdu u_dut (
        .clk(clk), .reset(reset), .iA1(a1), .iA2(a2), .iop(op), .istart(start),
        .out(out), .ooverflow(ovf), .obusy(busy), .ohi(hi), .olo(lo)
    );

    alu_mdu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .iA1(b1), .iA2(b2), .iop(op16), .istart(start16),
        .out(out16), .ooverflow(ovf16), .obusy(busy16), .ohi(hi16), .olo(lo16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: {overflow, result} from plain signed/unsigned arithmetic.
    function automatic logic [32:0] alu_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, s;
        logic [31:0] res;
        logic        ov;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ov  = 1'b0;
        res = 32'd0;
        case (o)
            4'd1: begin s = sx - sy; res = x - y; ov = (s != longint'($signed(res))); end
            4'd2: res = x | y;
            4'd3: res = x & y;
            4'd4: res = x ^ y;
            4'd5: res = {31'd0, sx < sy};
            4'd6: res = {31'd0, x < y};
            4'd7: res = ~(x | y);
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: res = 32'd0;
            default: begin s = sx + sy; res = x + y; ov = (s != longint'($signed(res))); end
        endcase
        return {ov, res};
    endfunction

    // Reference MDU: new {HI,LO} given current {HI,LO}.
    function automatic logic [63:0] mdu_ref(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] cur);
        longint          sx, sy, q, m;
        longint unsigned ux, uy, uq, um;
        logic [63:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = cur;
        case (o)
            4'd8:  r = sx * sy;
            4'd9:  r = ux * uy;
            4'd10: if (y != 32'd0) begin q = sx / sy; m = sx % sy; r = {m[31:0], q[31:0]}; end
            4'd11: if (y != 32'd0) begin uq = ux / uy; um = ux % uy; r = {um[31:0], uq[31:0]}; end
            4'd12: r = {x, cur[31:0]};
            4'd13: r = {cur[63:32], x};
            default: r = cur;
        endcase
        return r;
    endfunction

    task automatic alu_vec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] e;
        op = o; a1 = x; a2 = y;
        #1;
        e = alu_ref(o, x, y);
        check("alu", {31'd0, ovf, out}, {31'd0, e});
    endtask

    task automatic run_mdu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        int ncyc;
        ncyc = (o < 4'd10) ? 5 : 10;
        op = o; a1 = x; a2 = y; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_rise", {63'd0, busy}, 64'd1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 2) check("hilo_hold", {hi, lo}, m_hilo);
            n++;
            tick();
        end
        check("busy_len", 64'(n), 64'(ncyc));
        m_hilo = mdu_ref(o, x, y, m_hilo);
        check("hilo", {hi, lo}, m_hilo);
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] x);
        op = o; a1 = x; start = 1'b1;
        tick();
        start = 1'b0;
        check("mt_busy", {63'd0, busy}, 64'd0);
        m_hilo = mdu_ref(o, x, 32'd0, m_hilo);
        check("mt_hilo", {hi, lo}, m_hilo);
    endtask

    initial begin
        int          n;
        logic [3:0]  o;
        logic [31:0] x, y;

        reset = 1'b1; start = 1'b0; op = 4'd0; a1 = 32'd0; a2 = 32'd0;
        start16 = 1'b0; op16 = 4'd0; b1 = 16'd0; b2 = 16'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo16", {32'd0, hi16, lo16}, 64'd0);

        // Directed ALU corner cases with hand-derived expectations
        op = 4'd0; a1 = 32'h7FFFFFFF; a2 = 32'd1; #1;
        check("add_ovf", {31'd0, ovf, out}, {31'd0, 1'b1, 32'h80000000});
        a1 = 32'hFFFFFFFF; #1;
        check("add_carry", {31'd0, ovf, out}, {31'd0, 1'b0, 32'h00000000});
        op = 4'd5; #1;
        check("slt", {32'd0, out}, 64'd1);
        op = 4'd6; #1;
        check("sltu", {32'd0, out}, 64'd0);
        op = 4'd1; a1 = 32'h80000000; a2 = 32'd1; #1;
        check("sub_ovf", {31'd0, ovf, out}, {31'd0, 1'b1, 32'h7FFFFFFF});

        for (int i = 0; i < 48; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            if (i % 6 == 0) x = 32'h7FFFFFFF;
            if (i % 6 == 1) y = 32'h80000000;
            alu_vec(o, x, y);
        end

        // Directed MDU cases
        run_mdu(4'd8, 32'hFFFFFFFE, 32'd3);
        check("mult_k", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_mdu(4'd9, 32'hFFFFFFFF, 32'd2);
        check("multu_k", {hi, lo}, 64'h00000001_FFFFFFFE);
        run_mdu(4'd10, 32'hFFFFFFF9, 32'd2);
        check("div_k", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        move_to(4'd12, 32'd5);
        move_to(4'd13, 32'd9);
        run_mdu(4'd11, 32'd7, 32'd0);
        check("divz_k", {hi, lo}, 64'h00000005_00000009);
        run_mdu(4'd10, 32'h80000000, 32'hFFFFFFFF);
        check("divmin_k", {hi, lo}, 64'h00000000_80000000);

        // ALU op with istart has no sequential effect
        op = 4'd2; a1 = 32'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        check("alu_start_busy", {63'd0, busy}, 64'd0);
        check("alu_start_hilo", {hi, lo}, m_hilo);

        for (int i = 0; i < 12; i++) begin
            o = 4'(8 + $urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) y = 32'($urandom_range(1, 9));
            if (i % 4 == 2) x = -x;
            run_mdu(o, x, y);
        end

        // DIV start during a MULT is ignored; ALU stays usable while busy
        op = 4'd8; a1 = 32'hFFFFFFFE; a2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op = 4'd10; a1 = 32'd100; a2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        op = 4'd0; a1 = 32'd5; a2 = 32'd6; #1;
        check("alu_busy", {32'd0, out}, 64'd11);
        n = 2;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("ign_len", 64'(n), 64'd5);
        m_hilo = mdu_ref(4'd8, 32'hFFFFFFFE, 32'd3, m_hilo);
        check("ign_hilo", {hi, lo}, m_hilo);
        repeat (12) tick();
        check("ign_late", {hi, lo}, m_hilo);
        check("ign_idle", {63'd0, busy}, 64'd0);

        // Reset abandons a divide in progress
        op = 4'd10; a1 = 32'd100; a2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hilo = 64'd0;
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_hilo", {hi, lo}, m_hilo);
        repeat (15) tick();
        check("rstmid_late", {hi, lo}, m_hilo);

        // Reset wins over a simultaneous start
        op = 4'd9; a1 = 32'd3; a2 = 32'd4; start = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_prio", {63'd0, busy}, 64'd0);
        tick();
        check("rst_prio2", {63'd0, busy, hi, lo} == 64'd0 ? 64'd0 : 64'd1, 64'd0);

        // Back-to-back after a completed op
        run_mdu(4'd9, 32'd6, 32'd7);
        run_mdu(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // 16-bit instance
        op16 = 4'd9; b1 = 16'hFFFF; b2 = 16'hFFFF; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        n = 0;
        while (busy16 === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("w16_len", 64'(n), 64'd5);
        check("w16_hilo", {32'd0, hi16, lo16}, 64'h0000_0000_FFFE_0001);
        op16 = 4'd0; b1 = 16'h7FFF; b2 = 16'h0001; #1;
        check("w16_add", {47'd0, ovf16, out16}, {47'd0, 1'b1, 16'h8000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (>= 8, even).
REQ-002 SHALL provide parameter MUL_CYCLES, default 5, multiply busy duration in cycles (>= 1).
REQ-003 SHALL provide parameter DIV_CYCLES, default 10, divide busy duration in cycles (>= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port iA1  input  WIDTH  operand A.
REQ-007 SHALL have port iA2  input  WIDTH  operand B.
REQ-008 SHALL have port iop  input  4  operation select.
REQ-009 SHALL have port istart  input  1  launch MDU op in iop; ignored for ALU ops.
REQ-010 SHALL have port out  output  WIDTH  combinational ALU result.
REQ-011 SHALL have port ooverflow  output  1  signed overflow of ADD/SUB.
REQ-012 SHALL have port obusy  output  1  MDU operation in progress.
REQ-013 SHALL have ports ohi, olo  output  WIDTH each  HI/LO registers.

Function
REQ-014 iop encoding SHALL be: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SLT, 6 SLTU, 7 NOR, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MTHI, 13 MTLO; 14-15 behave as ADD.
REQ-015 out SHALL be combinational from iA1/iA2/iop, modulo 2^WIDTH; SLT/SLTU give 1 or 0 zero-extended.
REQ-016 For iop 8-13, out SHALL be 0 and ooverflow 0.
REQ-017 ooverflow SHALL be 1 only for ADD/SUB when operand signs and result sign indicate two's-complement overflow; carry out SHALL NOT set it.
REQ-018 MDU ops (8-11) SHALL start on an edge where istart=1, obusy=0, reset=0; operands captured at that edge.
REQ-019 On start, obusy SHALL rise the following cycle and stay high exactly MUL_CYCLES (mult) or DIV_CYCLES (div) cycles.
REQ-020 HI/LO SHALL update at the edge where obusy falls; ohi/olo unchanged while busy.
REQ-021 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit signed/unsigned product.
REQ-022 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with sign of dividend (signed); unsigned for DIVU.
REQ-023 Divide by zero: op SHALL run full DIV_CYCLES, then leave HI and LO unchanged.
REQ-024 Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
REQ-025 MTHI/MTLO with istart=1 and obusy=0 SHALL write iA1 to HI/LO at that edge; obusy stays 0.
REQ-026 istart while obusy=1 SHALL be ignored (no restart, no HI/LO write); ALU ops SHALL remain usable during busy.
REQ-027 istart with iop 0-7 or 14-15 SHALL have no sequential effect.
REQ-028 Back-to-back: new start accepted on first edge with obusy=0 after completion.

Reset
REQ-029 reset=1 at an edge SHALL clear ohi, olo, obusy and busy counter to 0, abandoning any operation in progress; no HI/LO write from it.
REQ-030 reset SHALL take priority over istart in the same cycle.

Verification
REQ-031 ADD 0x7FFFFFFF+1 -> out=0x80000000, ooverflow=1; ADD 0xFFFFFFFF+1 -> out=0, ooverflow=0; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-032 MULT -2 x 3 with istart -> obusy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU 0xFFFFFFFF x 2 -> HI=1, LO=0xFFFFFFFE.
REQ-033 DIV -7/2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 after MTHI 5, MTLO 9 -> HI=5, LO=9.
REQ-034 Start MULT, pulse istart with DIV at busy cycle 2 -> ignored; result equals MULT only, obusy total 5 cycles.
REQ-035 Start DIV, assert reset at busy cycle 4 -> next cycle obusy=0, HI=LO=0, no later write.
REQ-036 WIDTH=16 instance: MULTU 0xFFFF x 0xFFFF -> HI=0xFFFE, LO=0x0001.
